ps2_scancode_decoder: RTL and testbench
=======================================

Name: ps2_scancode_decoder

Overview:
- Downstream stage of the PS/2 keyboard receiver, running in the system clock domain.
- Consumes completed scan-code bytes (already synchronised, one-cycle strobe per byte) and tracks the E0 (extended) and F0 (break) prefixes.
- Emits one key event per make/break code into a small first-word-fall-through FIFO.
- The memory controller drains the FIFO through a valid/ready handshake.

Parameters:
- FIFO_DEPTH, 8, number of buffered key events; power of two, minimum 2.
- PAUSE_SKIP, 7, bytes discarded after an E1 prefix (remainder of the Pause sequence).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  synchronous reset, active-low.
- scan_valid  input  1  one-cycle strobe: scan_data holds a received byte.
- scan_data  input  8  received scan-code byte.
- ev_valid  output  1  FIFO head holds an event.
- ev_data  output  10  {release, extended, code[7:0]} of the FIFO head.
- ev_ready  input  1  consumer accepts the head when ev_valid and ev_ready are both 1 on an edge.
- ovf  output  1  sticky: an event was dropped because the FIFO was full.
- ovf_clr  input  1  clears ovf.
- proto_err  output  1  one-cycle pulse on a malformed prefix sequence.
- last_code  output  8  code of the most recent make event, for LED debug.

Behaviour:
- Reset:
  - Synchronous. Any edge with reset_n=0 clears the FIFO and returns the FSM to IDLE.
  - Outputs after reset: ev_valid=0, ev_data=0, ovf=0, proto_err=0, last_code=8'h00.
  - A byte strobed on a reset edge is ignored.
  - Reset mid-prefix (e.g. after F0) discards the prefix.
- FSM states: IDLE, EXT, BRK, EXT_BRK, SKIP. Prefixes are evaluated only on edges with scan_valid=1.
  - IDLE: E0->EXT; F0->BRK; E1->SKIP with skip counter=PAUSE_SKIP; other non-ignored byte -> emit {0,0,byte}, stay IDLE.
  - EXT: F0->EXT_BRK; other non-ignored byte -> emit {0,1,byte} then IDLE.
  - BRK: other non-ignored byte -> emit {1,0,byte} then IDLE.
  - EXT_BRK: other non-ignored byte -> emit {1,1,byte} then IDLE.
  - SKIP: each byte decrements the counter; when the counter reaches 0 -> IDLE. No events and no proto_err in SKIP.
- Ignored bytes: FA, AA, EE, FE, 00, FF.
  - Dropped in any state except SKIP; the state is unchanged.
- Malformed prefixes: pulse proto_err for one cycle, then resync.
  - E0 in EXT, BRK or EXT_BRK -> EXT.
  - F0 in BRK or EXT_BRK -> stay.
  - E1 outside IDLE -> SKIP.
- Emit timing:
  - The FIFO write happens on the same edge that samples the completing byte.
  - If the FIFO was empty, ev_valid=1 in the following cycle (latency 1).
  - last_code updates on the same edge, for make events only.
- FIFO:
  - FWFT; ev_data is valid whenever ev_valid=1 and is stable until popped.
  - Pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. Occupancy count is log2(FIFO_DEPTH)+1 bits.
  - Full with a write and no pop: the event is dropped and ovf is set.
  - Full with a write and a pop on the same edge: both succeed; occupancy is unchanged.
  - Empty with a write: no pop is possible; occupancy becomes 1.
  - ovf_clr and a new overflow on the same edge: ovf stays 1 (set wins).
- No combinational path from scan_* to ev_*. ev_ready affects only pop and pointer state.

Decomposition:
- Shared package ps2_pkg holds:
  - prefix and ignore byte constants: PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1, PS2_ACK=8'hFA, PS2_BAT=8'hAA, PS2_ECHO=8'hEE, PS2_RESEND=8'hFE;
  - FSM state encoding;
  - event field positions: release=bit9, extended=bit8.
- One sub-module: ps2_event_fifo, a parameterised FWFT FIFO (width 10, depth FIFO_DEPTH) that drives ovf. The decoder FSM lives in the top.

Test Plan:
- Make/break: bytes 1C, F0, 1C with ev_ready=1 -> events 0x01C then 0x21C; last_code=1C; proto_err never pulses.
- Extended: bytes E0, 75, E0, F0, 75 -> events 0x175 then 0x375.
- Overflow: ev_ready=0, FIFO_DEPTH+2 make codes 01..0A -> FIFO holds 01..08; ovf=1 after the 9th byte; popping yields 01..08 in order, then ev_valid=0. Assert ovf_clr -> ovf=0.
- Simultaneous full write + pop: fill to 8, strobe 2B on the same edge as a pop -> count stays 8; 2B appears last.
- Noise and Pause: bytes FA, AA, then E1 14 77 E1 F0 14 F0 77, then 1C -> exactly one event 0x01C; proto_err never pulses.
- Malformed prefix and reset: bytes F0, E0, 6B -> proto_err one pulse, event 0x16B. Byte F0 then reset_n low for one edge, then 1C -> event 0x01C; all outputs zero during reset.

Source files
------------

// File: rtl/ps2_scancode_decoder_pkg.sv
// Shared constants for the PS/2 scan-code decoder: prefix/ignore bytes,
// FSM encoding and key-event field layout.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_BAT    = 8'hAA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RESEND = 8'hFE;

    localparam int EV_W   = 10;
    localparam int EV_REL = 9;
    localparam int EV_EXT = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_SKIP
    } ps2_state_t;

    // Keyboard status/handshake bytes that never form part of a key code.
    function automatic logic is_ignored(input logic [7:0] b);
        return b inside {PS2_ACK, PS2_BAT, PS2_ECHO, PS2_RESEND, 8'h00, 8'hFF};
    endfunction

endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// Key-event stream from the decoder to the memory controller (valid/ready).
interface ps2_scancode_decoder_if;

    logic                     ev_valid;
    logic [ps2_pkg::EV_W-1:0] ev_data;
    logic                     ev_ready;

    modport master (output ev_valid, output ev_data, input ev_ready);
    modport slave  (input ev_valid, input ev_data, output ev_ready);

endinterface

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through event FIFO with sticky overflow flag.
module ps2_event_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    output logic         rd_valid,
    output logic [W-1:0] rd_data,
    input  logic         rd_ready,
    output logic         ovf,
    input  logic         ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, pop, push;

    assign full     = (count == FULL_CNT);
    assign rd_valid = (count != '0);
    assign pop      = rd_valid && rd_ready;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign push     = wr_en && (!full || pop);
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_en && full && !pop) ovf <= 1'b1;
            else if (ovf_clr)          ovf <= 1'b0;
        end
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Turns a stream of PS/2 scan-code bytes into {release, extended, code}
// key events, buffered in a FWFT FIFO for the memory controller.
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int PAUSE_SKIP = 7
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          scan_valid,
    input  logic [7:0]                    scan_data,
    ps2_scancode_decoder_if.master        ev,
    output logic                          ovf,
    input  logic                          ovf_clr,
    output logic                          proto_err,
    output logic [7:0]                    last_code
);

    localparam int SKW = (PAUSE_SKIP < 2) ? 1 : $clog2(PAUSE_SKIP + 1);
    localparam logic [SKW-1:0] SKIP_LOAD = SKW'(PAUSE_SKIP);
    localparam logic [SKW-1:0] SKIP_ONE  = SKW'(1);

    ps2_state_t      state_q, state_d;
    logic [SKW-1:0]  skip_q, skip_d;
    logic            emit, perr_d;
    logic [EV_W-1:0] ev_d;

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        emit    = 1'b0;
        perr_d  = 1'b0;
        ev_d    = '0;
        if (scan_valid) begin
            if (state_q == ST_SKIP) begin
                // Rest of the Pause sequence: count bytes blindly, whatever they are.
                skip_d = skip_q - 1'b1;
                if (skip_q <= SKIP_ONE) state_d = ST_IDLE;
            end else if (!is_ignored(scan_data)) begin
                case (scan_data)
                    PS2_PAUSE: begin
                        perr_d  = (state_q != ST_IDLE);
                        state_d = ST_SKIP;
                        skip_d  = SKIP_LOAD;
                    end
                    PS2_EXT: begin
                        perr_d  = (state_q != ST_IDLE);
                        state_d = ST_EXT;
                    end
                    PS2_BRK: begin
                        case (state_q)
                            ST_IDLE: state_d = ST_BRK;
                            ST_EXT:  state_d = ST_EXT_BRK;
                            default: perr_d  = 1'b1;
                        endcase
                    end
                    default: begin
                        emit         = 1'b1;
                        ev_d[EV_REL] = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
                        ev_d[EV_EXT] = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
                        ev_d[7:0]    = scan_data;
                        state_d      = ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            skip_q    <= '0;
            proto_err <= 1'b0;
            last_code <= 8'h00;
        end else begin
            state_q   <= state_d;
            skip_q    <= skip_d;
            proto_err <= perr_d;
            if (emit && !ev_d[EV_REL]) last_code <= scan_data;
        end
    end

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EV_W)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (emit),
        .wr_data  (ev_d),
        .rd_valid (ev.ev_valid),
        .rd_data  (ev.ev_data),
        .rd_ready (ev.ev_ready),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench: table of byte vectors with hand-computed events, plus
// sequences for overflow, full write+pop, and reset corner cases.
module tb_ps2_scancode_decoder;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       scan_valid;
    logic [7:0] scan_data;
    logic       ovf, ovf_clr, proto_err;
    logic [7:0] last_code;

    int errors = 0;
    int checks = 0;

    ps2_scancode_decoder_if evif();

    ps2_scancode_decoder #(.FIFO_DEPTH(8), .PAUSE_SKIP(7)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .scan_valid (scan_valid),
        .scan_data  (scan_data),
        .ev         (evif),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr),
        .proto_err  (proto_err),
        .last_code  (last_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        logic       ev;
        logic [9:0] d;
        logic       perr;
        logic [7:0] last;
    } vec_t;

    vec_t tbl[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        scan_valid = 1'b1;
        scan_data  = b;
        tick();
        scan_valid = 1'b0;
        scan_data  = 8'h00;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " ev_valid"},  32'(evif.ev_valid), 32'h0);
        check({tag, " ev_data"},   32'(evif.ev_data),  32'h0);
        check({tag, " ovf"},       32'(ovf),           32'h0);
        check({tag, " proto_err"}, 32'(proto_err),     32'h0);
        check({tag, " last_code"}, 32'(last_code),     32'h0);
    endtask

    initial begin
        logic [7:0] exp_q[$];

        reset_n       = 1'b0;
        scan_valid    = 1'b1;
        scan_data     = 8'h1C;
        ovf_clr       = 1'b0;
        evif.ev_ready = 1'b1;
        tick();
        tick();
        check_zero_outputs("reset");
        scan_valid = 1'b0;
        reset_n    = 1'b1;
        tick();
        check("byte_on_reset_edge ev_valid", 32'(evif.ev_valid), 32'h0);

        // make/break
        tbl.push_back('{8'h1C, 1'b1, 10'h01C, 1'b0, 8'h1C});
        tbl.push_back('{8'hF0, 1'b0, 10'h000, 1'b0, 8'h1C});
        tbl.push_back('{8'h1C, 1'b1, 10'h21C, 1'b0, 8'h1C});
        // extended make / extended break
        tbl.push_back('{8'hE0, 1'b0, 10'h000, 1'b0, 8'h1C});
        tbl.push_back('{8'h75, 1'b1, 10'h175, 1'b0, 8'h75});
        tbl.push_back('{8'hE0, 1'b0, 10'h000, 1'b0, 8'h75});
        tbl.push_back('{8'hF0, 1'b0, 10'h000, 1'b0, 8'h75});
        tbl.push_back('{8'h75, 1'b1, 10'h375, 1'b0, 8'h75});
        // noise, then Pause sequence swallowed whole
        tbl.push_back('{8'hFA, 1'b0, 10'h000, 1'b0, 8'h75});
        tbl.push_back('{8'hAA, 1'b0, 10'h000, 1'b0, 8'h75});
        tbl.push_back('{8'hE1, 1'b0, 10'h000, 1'b0, 8'h75});
        tbl.push_back('{8'h14, 1'b0, 10'h000, 1'b0, 8'h75});
        tbl.push_back('{8'h77, 1'b0, 10'h000, 1'b0, 8'h75});
        tbl.push_back('{8'hE1, 1'b0, 10'h000, 1'b0, 8'h75});
        tbl.push_back('{8'hF0, 1'b0, 10'h000, 1'b0, 8'h75});
        tbl.push_back('{8'h14, 1'b0, 10'h000, 1'b0, 8'h75});
        tbl.push_back('{8'hF0, 1'b0, 10'h000, 1'b0, 8'h75});
        tbl.push_back('{8'h77, 1'b0, 10'h000, 1'b0, 8'h75});
        tbl.push_back('{8'h1C, 1'b1, 10'h01C, 1'b0, 8'h1C});
        // malformed: E0 after F0 resyncs to extended
        tbl.push_back('{8'hF0, 1'b0, 10'h000, 1'b0, 8'h1C});
        tbl.push_back('{8'hE0, 1'b0, 10'h000, 1'b1, 8'h1C});
        tbl.push_back('{8'h6B, 1'b1, 10'h16B, 1'b0, 8'h6B});
        // ignored bytes keep the pending prefix
        tbl.push_back('{8'hF0, 1'b0, 10'h000, 1'b0, 8'h6B});
        tbl.push_back('{8'hFF, 1'b0, 10'h000, 1'b0, 8'h6B});
        tbl.push_back('{8'h00, 1'b0, 10'h000, 1'b0, 8'h6B});
        tbl.push_back('{8'h5A, 1'b1, 10'h25A, 1'b0, 8'h6B});
        tbl.push_back('{8'hE0, 1'b0, 10'h000, 1'b0, 8'h6B});
        tbl.push_back('{8'hEE, 1'b0, 10'h000, 1'b0, 8'h6B});
        tbl.push_back('{8'hFE, 1'b0, 10'h000, 1'b0, 8'h6B});
        tbl.push_back('{8'h4A, 1'b1, 10'h14A, 1'b0, 8'h4A});
        // double F0 is malformed but keeps the break
        tbl.push_back('{8'hF0, 1'b0, 10'h000, 1'b0, 8'h4A});
        tbl.push_back('{8'hF0, 1'b0, 10'h000, 1'b1, 8'h4A});
        tbl.push_back('{8'h29, 1'b1, 10'h229, 1'b0, 8'h4A});

        evif.ev_ready = 1'b1;
        foreach (tbl[i]) begin
            send(tbl[i].b);
            check($sformatf("vec%0d ev_valid", i), 32'(evif.ev_valid), 32'(tbl[i].ev));
            if (tbl[i].ev)
                check($sformatf("vec%0d ev_data", i), 32'(evif.ev_data), 32'(tbl[i].d));
            check($sformatf("vec%0d proto_err", i), 32'(proto_err), 32'(tbl[i].perr));
            check($sformatf("vec%0d last_code", i), 32'(last_code), 32'(tbl[i].last));
            tick();
            check($sformatf("vec%0d perr_gone", i), 32'(proto_err), 32'h0);
        end

        // overflow: ten makes into an 8-deep FIFO with no consumer
        evif.ev_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            send(8'(i));
            if (i == 8) check("ovf_before_full_write", 32'(ovf), 32'h0);
            if (i == 9) check("ovf_after_9th", 32'(ovf), 32'h1);
        end
        evif.ev_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("ovf_pop%0d valid", i), 32'(evif.ev_valid), 32'h1);
            check($sformatf("ovf_pop%0d data", i), 32'(evif.ev_data), 32'(i));
            tick();
        end
        check("ovf_drained ev_valid", 32'(evif.ev_valid), 32'h0);
        check("ovf_sticky", 32'(ovf), 32'h1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_cleared", 32'(ovf), 32'h0);

        // full FIFO: write and pop on the same edge both succeed
        evif.ev_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(8'(8'h11 + i));
        evif.ev_ready = 1'b1;
        send(8'h2B);
        evif.ev_ready = 1'b0;
        check("full_wr_pop ovf", 32'(ovf), 32'h0);
        exp_q = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h2B};
        evif.ev_ready = 1'b1;
        foreach (exp_q[i]) begin
            check($sformatf("full_wr_pop%0d valid", i), 32'(evif.ev_valid), 32'h1);
            check($sformatf("full_wr_pop%0d data", i), 32'(evif.ev_data), 32'(exp_q[i]));
            tick();
        end
        check("full_wr_pop drained", 32'(evif.ev_valid), 32'h0);

        // overflow set and clear on the same edge: set wins
        evif.ev_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(8'(8'h21 + i));
        ovf_clr = 1'b1;
        send(8'h30);
        ovf_clr = 1'b0;
        check("ovf_set_wins", 32'(ovf), 32'h1);
        check("ovf_head_kept", 32'(evif.ev_data), 32'h021);

        // reset mid-prefix discards the pending break and the FIFO
        send(8'hF0);
        reset_n = 1'b0;
        tick();
        check_zero_outputs("mid_reset");
        reset_n = 1'b1;
        evif.ev_ready = 1'b1;
        send(8'h1C);
        check("post_reset ev_valid", 32'(evif.ev_valid), 32'h1);
        check("post_reset ev_data", 32'(evif.ev_data), 32'h01C);
        check("post_reset last_code", 32'(last_code), 32'h1C);
        tick();
        check("post_reset drained", 32'(evif.ev_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
